tiny_nn_host_driver: RTL and testbench
======================================

// Module: tiny_nn_host_driver
// PURPOSE
// Host-side initiator for the tiny_nn convolve command stream. It builds the 16-bit words the NN
// core consumes: command word, then 8 parameter words, then a run of value words. It also
// rebuilds 16-bit accumulate results from the core's 8-bit result bytes. It sits between a test
// harness or CPU shim and the NN top-level pins, and gives them a register/stream interface.
// PARAMETERS
// CountWidth    12  width of the convolve count field (word bits [CountWidth-1:0])
// NumParams      8  parameter words per convolve (array width 4 x height 2)
// ValFifoDepth  16  value FIFO entries (power of 2)
// ResultDrop     1  leading result pairs discarded per convolve (core pipeline fill)
// PORTS
// clk_i        in   1   clock
// rst_ni       in   1   async active-low reset
// param_wr_i   in   1   write param_i into parameter bank entry param_idx_i
// param_idx_i  in   3   parameter bank index
// param_i      in   16  parameter value (fp_t bits)
// val_valid_i  in   1   push val_i into value FIFO
// val_i        in   16  value (fp_t bits)
// val_ready_o  out  1   value FIFO not full
// start_i      in   1   launch convolve with count_i
// count_i      in   12  convolve count N (runs N+1 value pairs)
// busy_o       out  1   convolve in progress
// done_o       out  1   1-cycle pulse after the final exec cycle
// underrun_o   out  1   sticky: FIFO empty during an exec cycle; cleared by start_i
// res_valid_o  out  1   res_o valid (1-cycle pulse, no backpressure)
// res_o        out  16  reassembled result {hi byte, lo byte}
// nn_data_o    out  16  word driven to NN core data input
// nn_data_i    in   8   byte from NN core data output
// BEHAVIOUR
// - Reset: state Idle, FIFO empty, param bank 0, busy_o/done_o/underrun_o/res_valid_o=0,
//   res_o=0, nn_data_o=IDLE_WORD={~CmdOpConvolve,12'h000}. Outputs are registered.
// - State machine: Idle -> Cmd -> Param -> Exec -> Idle.
// - Idle: nn_data_o=IDLE_WORD. start_i=1 latches cnt=count_i and clears underrun, then goes to Cmd.
//   start_i is ignored while busy_o=1.
// - Cmd (1 cycle): nn_data_o={CmdOpConvolve,cnt}; busy_o=1.
// - Param (NumParams cycles): nn_data_o=bank[k] for k=0..NumParams-1 in ascending order.
// - Exec: 2*(cnt+1) cycles. Phase p alternates 0,1 starting at 0. Each cycle pops one FIFO entry
//   to nn_data_o. If the FIFO is empty, drive 16'h0000 and set underrun_o.
// - Result capture, Exec only: on phase 0, hi=nn_data_i; on phase 1, {hi,nn_data_i} forms the
//   pair result. The first ResultDrop pairs are discarded. Each later pair gives
//   res_valid_o=1 and res_o=pair the next cycle. Results per convolve = cnt+1-ResultDrop
//   (0 if negative).
// - The last exec cycle (phase 1, pair cnt) goes to Idle. done_o pulses the next cycle with the
//   final res_valid_o. busy_o falls with done_o.
// - Parameter bank: written only in Idle; param_wr_i during busy is ignored. The bank holds its
//   contents across convolves.
// - FIFO: pushes accepted when val_valid_i && val_ready_o. A push when full is dropped.
//   Simultaneous push and pop when full is allowed (level unchanged). Pointers wrap modulo
//   ValFifoDepth. The FIFO is not flushed at done, so leftovers feed the next convolve.
// - cnt is CountWidth bits unsigned; 12'hFFF gives 4096 pairs, with no overflow in the internal
//   13-bit pair counter.
// - rst_ni low mid-operation: immediately Idle/IDLE_WORD and FIFO emptied. The core also
//   resets to idle, so there is no partial-command hazard.
// TESTING
// - Write bank 0..7=16'h0101*k; push 4 vals; start count=1 -> nn_data_o: cmd {CmdOpConvolve,12'h001},
//   8 params in order, 4 vals; done_o 14 cycles after start.
// - Core model returns result 16'hABCD for pair 1 -> res_o=16'hABCD, exactly one res_valid_o
//   (pair 0 dropped).
// - Start count=2 with 3 vals queued -> last 3 exec words 0, underrun_o=1; next start clears it.
// - Fill FIFO to 16 -> val_ready_o=0, 17th push dropped; push+pop during exec keeps level at 16.
// - param_wr_i and start_i during Exec -> bank unchanged, no relaunch; count=12'hFFF -> 8192
//   exec cycles, 4095 results.
// - Assert rst_ni mid-Param -> nn_data_o=IDLE_WORD same cycle, busy_o=0, val_ready_o=1.

Source files
------------

// File: rtl/tiny_nn_host_driver.sv
// tiny_nn_host_driver: streams command, parameter and value words to the tiny_nn core
// and reassembles 16-bit accumulate results from the core's 8-bit result bytes.
module tiny_nn_host_driver #(
    parameter int CountWidth = 12,
    parameter int NumParams = 8,
    parameter int ValFifoDepth = 16,
    parameter int ResultDrop = 1,
    parameter logic [15-CountWidth:0] CmdOpConvolve = 4'h1
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic                          param_wr_i,
    input  logic [$clog2(NumParams)-1:0]  param_idx_i,
    input  logic [15:0]                   param_i,
    input  logic                          val_valid_i,
    input  logic [15:0]                   val_i,
    output logic                          val_ready_o,
    input  logic                          start_i,
    input  logic [CountWidth-1:0]         count_i,
    output logic                          busy_o,
    output logic                          done_o,
    output logic                          underrun_o,
    output logic                          res_valid_o,
    output logic [15:0]                   res_o,
    output logic [15:0]                   nn_data_o,
    input  logic [7:0]                    nn_data_i
);
    localparam int PW = $clog2(NumParams);
    localparam int FW = $clog2(ValFifoDepth);
    localparam logic [15:0] IDLE_WORD = {~CmdOpConvolve, {CountWidth{1'b0}}};
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_CMD = 2'd1;
    localparam logic [1:0] ST_PARAM = 2'd2;
    localparam logic [1:0] ST_EXEC = 2'd3;

    logic [1:0] state;
    logic [CountWidth-1:0] cnt;
    logic [PW-1:0] k, k_nxt;
    logic [CountWidth:0] pair;
    logic phase;
    logic [7:0] hi;
    logic [15:0] bank [NumParams];
    logic [15:0] fifo [ValFifoDepth];
    logic [FW-1:0] rd_ptr, wr_ptr;
    logic [FW:0] level;
    logic last_param, last_exec, pop, pop_ok, push_ok, empty, full, keep_res;
    logic [15:0] pop_word;

    // pops happen on the edge that enters each exec cycle, so the word is on the pins for that cycle
    assign k_nxt = k + 1'b1;
    assign last_param = state == ST_PARAM && k == PW'(NumParams - 1);
    assign last_exec = state == ST_EXEC && phase && pair == {1'b0, cnt};
    assign pop = last_param || (state == ST_EXEC && !last_exec);
    assign empty = level == '0;
    assign full = level == (FW+1)'(ValFifoDepth);
    assign pop_ok = pop && !empty;
    assign push_ok = val_valid_i && (!full || pop_ok);
    assign val_ready_o = !full;
    assign pop_word = empty ? 16'h0000 : fifo[rd_ptr];
    assign keep_res = phase && pair >= (CountWidth+1)'(ResultDrop);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state <= ST_IDLE;
            cnt <= '0;
            k <= '0;
            pair <= '0;
            phase <= 1'b0;
            hi <= '0;
            busy_o <= 1'b0;
            done_o <= 1'b0;
            underrun_o <= 1'b0;
            res_valid_o <= 1'b0;
            res_o <= '0;
            nn_data_o <= IDLE_WORD;
            for (int i = 0; i < NumParams; i++) bank[i] <= '0;
        end else begin
            done_o <= 1'b0;
            res_valid_o <= 1'b0;
            if (pop && empty) underrun_o <= 1'b1;
            case (state)
                ST_IDLE: begin
                    if (param_wr_i) bank[param_idx_i] <= param_i;
                    if (start_i) begin
                        state <= ST_CMD;
                        cnt <= count_i;
                        underrun_o <= 1'b0;
                        busy_o <= 1'b1;
                        nn_data_o <= {CmdOpConvolve, count_i};
                    end
                end
                ST_CMD: begin
                    state <= ST_PARAM;
                    k <= '0;
                    nn_data_o <= bank[0];
                end
                ST_PARAM: begin
                    k <= k_nxt;
                    nn_data_o <= last_param ? pop_word : bank[k_nxt];
                    if (last_param) begin
                        state <= ST_EXEC;
                        pair <= '0;
                        phase <= 1'b0;
                    end
                end
                default: begin
                    phase <= ~phase;
                    if (!phase) hi <= nn_data_i;
                    else pair <= pair + 1'b1;
                    if (keep_res) begin
                        res_valid_o <= 1'b1;
                        res_o <= {hi, nn_data_i};
                    end
                    if (last_exec) begin
                        state <= ST_IDLE;
                        busy_o <= 1'b0;
                        done_o <= 1'b1;
                        nn_data_o <= IDLE_WORD;
                    end else begin
                        nn_data_o <= pop_word;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            level <= '0;
        end else begin
            rd_ptr <= rd_ptr + FW'(pop_ok);
            wr_ptr <= wr_ptr + FW'(push_ok);
            level <= level + (FW+1)'(push_ok) - (FW+1)'(pop_ok);
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_ok) fifo[wr_ptr] <= val_i;
    end
endmodule

// File: tb/tb_tiny_nn_host_driver.sv
// tb_tiny_nn_host_driver: table-driven convolve runs with a FIFO/bank model and a result scoreboard.
// The core stand-in echoes the high byte of every word it receives.
module tb_tiny_nn_host_driver;
    logic clk_i = 1'b0, rst_ni = 1'b0;
    logic param_wr_i = 1'b0, val_valid_i = 1'b0, start_i = 1'b0;
    logic [2:0] param_idx_i = '0;
    logic [15:0] param_i = '0, val_i = '0;
    logic [11:0] count_i = '0;
    logic val_ready_o, busy_o, done_o, underrun_o, res_valid_o;
    logic [15:0] res_o, nn_data_o;
    logic [7:0] nn_data_i;

    localparam logic [15:0] IDLE_WORD = 16'hE000;

    tiny_nn_host_driver dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .param_wr_i(param_wr_i), .param_idx_i(param_idx_i),
        .param_i(param_i), .val_valid_i(val_valid_i), .val_i(val_i), .val_ready_o(val_ready_o),
        .start_i(start_i), .count_i(count_i), .busy_o(busy_o), .done_o(done_o),
        .underrun_o(underrun_o), .res_valid_o(res_valid_o), .res_o(res_o),
        .nn_data_o(nn_data_o), .nn_data_i(nn_data_i)
    );

    always #5 clk_i = ~clk_i;
    assign nn_data_i = nn_data_o[15:8];

    typedef struct {
        logic [11:0] cnt;
        int nvals;
        logic ur;
        int nres;
    } vec_t;

    int checks = 0, errors = 0, nres;
    logic [15:0] mq[$], exp_r[$], last_res;
    logic [15:0] bank_m[8];
    vec_t tbl[4];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic push_val(input logic [15:0] v);
        val_valid_i = 1'b1;
        val_i = v;
        @(posedge clk_i);
        #1 val_valid_i = 1'b0;
        if (mq.size() < 16) mq.push_back(v);
    endtask

    task automatic write_param(input int i, input logic [15:0] v);
        param_wr_i = 1'b1;
        param_idx_i = 3'(i);
        param_i = v;
        @(posedge clk_i);
        #1 param_wr_i = 1'b0;
        bank_m[i] = v;
    endtask

    task automatic run_conv(input logic [11:0] n, input bit push_ex, input bit disturb);
        logic [15:0] ew[$];
        int nw, total, have;
        nw = 2 * (int'(n) + 1);
        total = 9 + nw;
        have = mq.size();
        nres = 0;
        ew.push_back({4'h1, n});
        for (int i = 0; i < 8; i++) ew.push_back(bank_m[i]);
        for (int i = 0; i < nw; i++) ew.push_back(i < have ? mq[i] : 16'h0000);
        for (int j = 1; j <= int'(n); j++) exp_r.push_back({ew[9+2*j][15:8], ew[10+2*j][15:8]});
        start_i = 1'b1;
        count_i = n;
        @(posedge clk_i);
        #1 start_i = 1'b0;
        for (int c = 0; c <= total; c++) begin
            val_valid_i = push_ex && c >= 8 && c < 8 + nw;
            val_i = 16'hC000 + 16'(c);
            param_wr_i = disturb && c >= 9 && c < total;
            param_idx_i = 3'(c);
            param_i = 16'hDEAD;
            start_i = param_wr_i;
            count_i = 12'd5;
            @(negedge clk_i);
            if (c < total) chk("word", nn_data_o, ew[c]);
            else begin
                chk("done", done_o, 1);
                chk("busy_fall", busy_o, 0);
                chk("idle_word", nn_data_o, IDLE_WORD);
            end
            if (c == 0) begin
                chk("busy", busy_o, 1);
                chk("underrun_clr", underrun_o, 0);
            end
            if (res_valid_o) begin
                nres++;
                last_res = res_o;
                if (exp_r.size() == 0) chk("res_extra", 1, 0);
                else chk("res", res_o, exp_r.pop_front());
            end
            @(posedge clk_i);
            #1;
        end
        val_valid_i = 1'b0;
        param_wr_i = 1'b0;
        start_i = 1'b0;
        chk("res_missing", exp_r.size(), 0);
        @(negedge clk_i);
        chk("done_pulse", done_o, 0);
        chk("no_relaunch", busy_o, 0);
        for (int i = 0; i < nw && i < have; i++) void'(mq.pop_front());
        if (push_ex) for (int c = 8; c < 8 + nw; c++) mq.push_back(16'hC000 + 16'(c));
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        tbl[0] = '{cnt: 12'd2, nvals: 3, ur: 1'b1, nres: 2};
        tbl[1] = '{cnt: 12'd0, nvals: 2, ur: 1'b0, nres: 0};
        tbl[2] = '{cnt: 12'd3, nvals: 8, ur: 1'b0, nres: 3};
        tbl[3] = '{cnt: 12'd4, nvals: 6, ur: 1'b1, nres: 4};
        for (int i = 0; i < 8; i++) bank_m[i] = '0;
        #12;
        chk("rst_word", nn_data_o, IDLE_WORD);
        chk("rst_busy", busy_o, 0);
        chk("rst_flags", {done_o, underrun_o, res_valid_o}, 0);
        chk("rst_res", res_o, 0);
        chk("rst_ready", val_ready_o, 1);
        @(posedge clk_i);
        #1 rst_ni = 1'b1;
        for (int i = 0; i < 8; i++) write_param(i, 16'h0101 * 16'(i));
        push_val(16'h1200);
        push_val(16'h3400);
        push_val(16'hAB00);
        push_val(16'hCD00);
        run_conv(12'd1, 0, 0);
        chk("abcd_count", nres, 1);
        chk("abcd_value", last_res, 16'hABCD);
        chk("abcd_ur", underrun_o, 0);
        for (int t = 0; t < 4; t++) begin
            for (int i = 0; i < tbl[t].nvals; i++) push_val(16'h1000 * 16'(t + 1) + 16'h0123 * 16'(i));
            run_conv(tbl[t].cnt, 0, 0);
            chk("tbl_underrun", underrun_o, tbl[t].ur);
            chk("tbl_nres", nres, tbl[t].nres);
        end
        for (int i = 0; i < 16; i++) begin
            @(negedge clk_i);
            chk("fill_ready", val_ready_o, 1);
            @(posedge clk_i);
            #1 push_val(16'hA000 + 16'(i));
        end
        @(negedge clk_i);
        chk("full_ready", val_ready_o, 0);
        push_val(16'hA0FF);
        run_conv(12'd3, 1, 0);
        chk("full_level_kept", val_ready_o, 0);
        chk("full_ur", underrun_o, 0);
        run_conv(12'd7, 0, 0);
        chk("drain_nres", nres, 7);
        chk("drain_ur", underrun_o, 0);
        chk("drain_ready", val_ready_o, 1);
        run_conv(12'hFFF, 0, 1);
        chk("max_nres", nres, 4095);
        chk("max_ur", underrun_o, 1);
        for (int i = 0; i < 4; i++) push_val(16'h5500 + 16'h1111 * 16'(i));
        run_conv(12'd1, 0, 0);
        chk("bank_kept_ur", underrun_o, 0);
        push_val(16'h7777);
        push_val(16'h8888);
        start_i = 1'b1;
        count_i = 12'd5;
        @(posedge clk_i);
        #1 start_i = 1'b0;
        repeat (3) @(posedge clk_i);
        #3 rst_ni = 1'b0;
        #1;
        chk("midrst_word", nn_data_o, IDLE_WORD);
        chk("midrst_busy", busy_o, 0);
        chk("midrst_ready", val_ready_o, 1);
        mq.delete();
        for (int i = 0; i < 8; i++) bank_m[i] = '0;
        @(posedge clk_i);
        #1 rst_ni = 1'b1;
        push_val(16'h1111);
        push_val(16'h2222);
        run_conv(12'd0, 0, 0);
        chk("post_rst_ur", underrun_o, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
